citadel_sequence_gate: RTL and testbench

Parametrised successor to the single-byte Sentinel lock. It authorises only on an ordered multi-byte key sequence, with every byte arriving inside a per-byte time window. Repeated failures escalate into a timed lockout, and a sticky tamper latch is driven by output loopback (drive-fight) monitoring. The block sits between the DIP/key interface and the 7-segment and status arrays of the Citadel top level.

---
 rtl/citadel_pkg.sv | 23 ++
 rtl/citadel_fight_monitor.sv | 29 ++
 rtl/citadel_sequence_gate.sv | 151 +++++++++++++++
 tb/tb_citadel_sequence_gate.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/citadel_pkg.sv
// rtl/citadel_pkg.sv - shared state encoding and display/status constants for the Citadel sequence gate
package citadel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_AUTHORIZED,
        ST_LOCKOUT,
        ST_TAMPERED
    } state_t;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_LOCKED   = 8'hC7;
    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
    localparam logic [7:0] SEG_LOCKOUT  = 8'h89;
    localparam logic [7:0] SEG_TAMPER   = 8'h86;
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    localparam logic [7:0] STATUS_ON     = 8'hFF;
    localparam logic [7:0] STATUS_OFF    = 8'h00;
    localparam logic [7:0] STATUS_OE_ALL = 8'hFF;

endpackage

// File: rtl/citadel_fight_monitor.sv
// rtl/citadel_fight_monitor.sv - saturating count of consecutive driven/sensed pin disagreements
module citadel_fight_monitor #(
    parameter int THRESHOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] driven,
    input  logic [7:0] sensed,
    output logic       trip
);

    localparam int CW = $clog2(THRESHOLD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(THRESHOLD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (driven == sensed) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign trip = (cnt == CNT_MAX);

endmodule

// File: rtl/citadel_sequence_gate.sv
// rtl/citadel_sequence_gate.sv - timed multi-byte key sequence lock with lockout escalation and tamper latch
module citadel_sequence_gate
    import citadel_pkg::*;
#(
    parameter int KEY_BYTES = 4,
    parameter logic [8*KEY_BYTES-1:0] KEY = 32'hB65AC30F,
    parameter int WIN_MIN = 3,
    parameter int WIN_MAX = 5,
    parameter int LOCKOUT_CYCLES = 20,
    parameter int MAX_FAILS = 3,
    parameter int FIGHT_THRESHOLD = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [7:0]                     key_in,
    input  logic                           key_valid,
    input  logic [7:0]                     uio_in,
    output logic [7:0]                     seg_out,
    output logic [7:0]                     status_out,
    output logic [7:0]                     status_oe,
    output logic                           authorized,
    output logic                           lockout,
    output logic                           tampered,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int GW = $clog2(WIN_MAX + 2);
    localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [GW-1:0] GAP_MIN     = GW'(WIN_MIN);
    localparam logic [GW-1:0] GAP_MAX     = GW'(WIN_MAX);
    localparam logic [GW-1:0] GAP_TIMEOUT = GW'(WIN_MAX + 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(KEY_BYTES - 1);
    localparam logic [LW-1:0] LT_INIT     = LW'(LOCKOUT_CYCLES);
    localparam logic [FW-1:0] FC_LAST     = FW'(MAX_FAILS - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [GW-1:0] gap;
    logic [LW-1:0] lt;
    logic [7:0]    exp_byte;
    logic          hit;
    logic          fail;
    logic          trip;

    citadel_fight_monitor #(
        .THRESHOLD(FIGHT_THRESHOLD)
    ) u_fight (
        .clk    (clk),
        .rst    (rst),
        .driven (status_out),
        .sensed (uio_in),
        .trip   (trip)
    );

    always_comb begin
        exp_byte = KEY[7:0];
        for (int i = 0; i < KEY_BYTES; i++) begin
            if (idx == IW'(i)) exp_byte = KEY[8*i +: 8];
        end
    end

    // A strobe outside the window or with the wrong byte is a fail; silence past the window is a timeout
    always_comb begin
        hit  = key_valid && (gap >= GAP_MIN) && (gap <= GAP_MAX) && (key_in == exp_byte);
        fail = key_valid ? !hit : (gap == GAP_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            gap        <= '0;
            lt         <= '0;
            fail_count <= '0;
        end else if (trip) begin
            state <= ST_TAMPERED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ena) begin
                        state <= ST_ARMED;
                        idx   <= '0;
                        gap   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!ena) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        gap   <= '0;
                    end else if (hit) begin
                        gap <= '0;
                        if (idx == IDX_LAST) begin
                            state      <= ST_AUTHORIZED;
                            fail_count <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (fail) begin
                        idx        <= '0;
                        gap        <= '0;
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == FC_LAST) begin
                            state <= ST_LOCKOUT;
                            lt    <= LT_INIT;
                        end
                    end else if (gap != GAP_TIMEOUT) begin
                        gap <= gap + 1'b1;
                    end
                end
                ST_AUTHORIZED: begin
                    if (!ena || key_valid) state <= ST_IDLE;
                end
                // Runs independently of ena so the penalty cannot be cut short
                ST_LOCKOUT: begin
                    if (lt == '0) begin
                        state      <= ST_IDLE;
                        fail_count <= '0;
                    end else begin
                        lt <= lt - 1'b1;
                    end
                end
                ST_TAMPERED: state <= ST_TAMPERED;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        seg_out = SEG_OFF;
        if (ena) begin
            case (state)
                ST_AUTHORIZED: seg_out = SEG_UNLOCKED;
                ST_LOCKOUT:    seg_out = SEG_LOCKOUT;
                ST_TAMPERED:   seg_out = SEG_TAMPER;
                default:       seg_out = SEG_LOCKED;
            endcase
        end
    end

    assign status_out = (state == ST_AUTHORIZED && ena) ? STATUS_ON : STATUS_OFF;
    assign status_oe  = STATUS_OE_ALL;
    assign authorized = (state == ST_AUTHORIZED);
    assign lockout    = (state == ST_LOCKOUT);
    assign tampered   = (state == ST_TAMPERED);

endmodule

// File: tb/tb_citadel_sequence_gate.sv
// tb/tb_citadel_sequence_gate.sv - directed/randomized self-checking bench for citadel_sequence_gate
module tb_citadel_sequence_gate;

    localparam int KB     = 4;
    localparam int WMIN   = 3;
    localparam int WMAX   = 5;
    localparam int LOCK_N = 20;
    localparam int MAXF   = 3;
    localparam int FIGHT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] key_in;
    logic       key_valid;
    logic [7:0] uio_in;
    logic [7:0] seg_out;
    logic [7:0] status_out;
    logic [7:0] status_oe;
    logic       authorized;
    logic       lockout;
    logic       tampered;
    logic [1:0] fail_count;

    logic       fight;
    logic [7:0] fight_val;

    int n_tests = 0;
    int n_fail  = 0;

    int m_idx;
    int m_fc;
    int m_auth;
    logic [7:0] key_b [KB];

    always #5 clk = ~clk;

    // Status pins loop straight back unless a fight is being forced
    assign uio_in = fight ? fight_val : status_out;

    citadel_sequence_gate #(
        .KEY_BYTES       (KB),
        .KEY             (32'hB65AC30F),
        .WIN_MIN         (WMIN),
        .WIN_MAX         (WMAX),
        .LOCKOUT_CYCLES  (LOCK_N),
        .MAX_FAILS       (MAXF),
        .FIGHT_THRESHOLD (FIGHT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .uio_in     (uio_in),
        .seg_out    (seg_out),
        .status_out (status_out),
        .status_oe  (status_oe),
        .authorized (authorized),
        .lockout    (lockout),
        .tampered   (tampered),
        .fail_count (fail_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait g cycles from a gap=0 cycle, strobe b, then check against the rule-level model
    task automatic present(input logic [7:0] b, input int g);
        repeat (g) tick();
        key_in    = b;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        if (g >= WMIN && g <= WMAX && b == key_b[m_idx]) begin
            m_idx++;
            if (m_idx == KB) begin
                m_idx  = 0;
                m_fc   = 0;
                m_auth = 1;
            end
        end else begin
            m_fc++;
            m_idx = 0;
        end
        chk("authorized", 32'(authorized), m_auth);
        chk("lockout", 32'(lockout), (m_fc == MAXF) ? 1 : 0);
        if (m_fc < MAXF) chk("fail_count", 32'(fail_count), m_fc);
    endtask

    task automatic raw_strobe(input logic [7:0] b, input int g);
        repeat (g) tick();
        key_in    = b;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        int drop;
        logic [7:0] b;

        key_b = '{8'h0F, 8'hC3, 8'h5A, 8'hB6};
        rst = 1'b1; ena = 1'b0; key_valid = 1'b0; key_in = 8'h00;
        fight = 1'b0; fight_val = 8'h00;
        m_idx = 0; m_fc = 0; m_auth = 0;

        tick(); tick();
        chk("rst_authorized", 32'(authorized), 0);
        chk("rst_lockout", 32'(lockout), 0);
        chk("rst_tampered", 32'(tampered), 0);
        chk("rst_fail_count", 32'(fail_count), 0);
        chk("rst_status", 32'(status_out), 8'h00);
        chk("rst_seg_off", 32'(seg_out), 8'hFF);
        chk("status_oe", 32'(status_oe), 8'hFF);
        ena = 1'b1;
        #1;
        chk("rst_seg_locked", 32'(seg_out), 8'hC7);
        rst = 1'b0;
        tick();

        for (int i = 0; i < KB; i++) present(key_b[i], 4);
        chk("auth_seg", 32'(seg_out), 8'hC1);
        chk("auth_status", 32'(status_out), 8'hFF);
        ena = 1'b0;
        #1;
        chk("ena_off_seg", 32'(seg_out), 8'hFF);
        chk("ena_off_status", 32'(status_out), 8'h00);
        tick();
        m_auth = 0;
        chk("ena_off_idle", 32'(authorized), 0);

        ena = 1'b1;
        tick();
        present(key_b[0], 2);
        present(key_b[0], 3);
        present(key_b[1], 5);
        repeat (6) tick();
        chk("pre_timeout_fc", 32'(fail_count), m_fc);
        tick();
        m_fc++;
        m_idx = 0;
        chk("timeout_fc", 32'(fail_count), m_fc);

        for (int i = 0; i < KB; i++) present(key_b[i], int'($urandom_range(WMIN, WMAX)));
        chk("rand_auth_fc", 32'(fail_count), 0);

        key_in    = 8'($urandom);
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        m_auth = 0;
        chk("relock_authorized", 32'(authorized), 0);
        chk("relock_seg", 32'(seg_out), 8'hC7);
        tick();

        present(8'h00, 4);
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            if (b == key_b[0]) b = 8'h00;
            present(b, int'($urandom_range(0, WMAX)));
        end
        chk("lockout_seg", 32'(seg_out), 8'h89);
        drop = int'($urandom_range(1, 15));
        for (int c = 1; c <= LOCK_N; c++) begin
            if (c == drop) ena = 1'b0;
            key_in    = 8'($urandom);
            key_valid = 1'($urandom_range(0, 1));
            tick();
        end
        key_valid = 1'b0;
        chk("lockout_hold", 32'(lockout), 1);
        tick();
        m_fc = 0;
        m_idx = 0;
        chk("lockout_end", 32'(lockout), 0);
        chk("lockout_end_fc", 32'(fail_count), 0);
        chk("lockout_end_seg", 32'(seg_out), 8'hFF);

        ena = 1'b1;
        tick();
        for (int i = 0; i < KB; i++) present(key_b[i], 4);
        fight_val = 8'h00;
        fight = 1'b1;
        tick(); tick();
        fight = 1'b0;
        chk("tamper_pre", 32'(tampered), 0);
        chk("tamper_pre_auth", 32'(authorized), 1);
        tick();
        chk("tamper_set", 32'(tampered), 1);
        chk("tamper_seg", 32'(seg_out), 8'h86);
        chk("tamper_auth", 32'(authorized), 0);
        chk("tamper_status", 32'(status_out), 8'h00);
        for (int i = 0; i < KB; i++) raw_strobe(key_b[i], 4);
        chk("tamper_sticky", 32'(tampered), 1);
        chk("tamper_no_auth", 32'(authorized), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_fc = 0; m_idx = 0; m_auth = 0;
        chk("tamper_rst", 32'(tampered), 0);
        chk("tamper_rst_seg", 32'(seg_out), 8'hC7);

        tick();
        for (int i = 0; i < KB - 1; i++) present(key_b[i], 4);
        tick(); tick();
        fight_val = 8'($urandom_range(1, 255));
        fight = 1'b1;
        tick(); tick();
        fight = 1'b0;
        key_in    = key_b[KB-1];
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("sim_tampered", 32'(tampered), 1);
        chk("sim_authorized", 32'(authorized), 0);
        tick();
        chk("sim_authorized_late", 32'(authorized), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_fc = 0; m_idx = 0; m_auth = 0;
        tick();
        present(8'h00, 4);
        present(key_b[0], 4);
        tick(); tick();
        fight_val = 8'h33;
        fight = 1'b1;
        tick();
        fight = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_fc = 0; m_idx = 0; m_auth = 0;
        chk("midrst_fc", 32'(fail_count), 0);
        chk("midrst_tampered", 32'(tampered), 0);
        chk("midrst_lockout", 32'(lockout), 0);
        chk("midrst_auth", 32'(authorized), 0);
        fight = 1'b1;
        tick();
        fight = 1'b0;
        for (int i = 0; i < KB; i++) present(key_b[i], (i == 0) ? WMIN : 4);
        chk("midrst_no_tamper", 32'(tampered), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
